// File: rtl/stack_arch_pkg.sv
// Purpose : shared architectural constants and memory-initiator FSM encoding
//           for the stack processor's memory port (also used by the fetch unit).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   AWIDTH_DEF / DWIDTH_DEF - default address and data widths of the memory port
//   mem_state_e             - 2-bit initiator state encoding (IDLE/SETUP/STROBE/HOLD)
//   wait_cnt_width()        - width of a counter that must hold 0..wait_cycles
package stack_arch_pkg;

    localparam int AWIDTH_DEF = 15;
    localparam int DWIDTH_DEF = 32;

    // The numeric values are shared with the fetch unit, so they are pinned
    // explicitly rather than left to enum auto-numbering.
    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_SETUP  = 2'd1,
        MS_STROBE = 2'd2,
        MS_HOLD   = 2'd3
    } mem_state_e;

    // The strobe counter counts 0..wait_cycles, so it needs room for
    // wait_cycles itself, not just wait_cycles-1.
    function automatic int wait_cnt_width(input int wait_cycles);
        return $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_master_if.sv
// Purpose : bundles the core-side request/response handshake and the
//           memory-side level-sensitive pins of the memory initiator.
// Latency : n/a (wiring only).
// Backpressure: req_valid/req_ready handshake; the response is a one-cycle pulse
//               with no ready, so the core must always accept rsp_valid.
//
// Signals:
//   req_valid/req_ready     - core request handshake
//   req_we/req_addr/req_wdata - request payload (1 = write)
//   rsp_valid/rsp_rdata     - completion pulse and read data
//   mem_addr/mem_wr/mem_rd/mem_wdata - to the memory's addr/wr/rd/data_in
//   mem_rdata               - from the memory's data_out (undefined when mem_rd=0)
//
// Modports: master = the initiator (mem_master); slave = core + memory side.
interface mem_master_if
    import stack_arch_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;

    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;

    logic [AWIDTH-1:0] mem_addr;
    logic              mem_wr;
    logic              mem_rd;
    logic [DWIDTH-1:0] mem_wdata;
    logic [DWIDTH-1:0] mem_rdata;

    modport master (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  mem_rdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output mem_addr,
        output mem_wr,
        output mem_rd,
        output mem_wdata
    );

    modport slave (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output mem_rdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  mem_addr,
        input  mem_wr,
        input  mem_rd,
        input  mem_wdata
    );

endinterface

// File: rtl/mem_master.sv
// Purpose : single-word memory initiator; drives the memory's level-sensitive
//           pins with a setup -> strobe -> hold sequence.
// Latency : accept edge -> SETUP (1) -> STROBE (WAIT_CYCLES) -> HOLD/rsp_valid,
//           i.e. rsp_valid in cycle WAIT_CYCLES+2, req_ready again in WAIT_CYCLES+3.
// Backpressure: req_ready only in IDLE (and not in reset); one request in flight,
//               requester holds req_* until accepted. rsp_valid cannot be stalled.
//
// Ports:
//   clk  - single rising-edge clock
//   rst  - synchronous active-high reset; aborts any in-flight access silently
//   bus  - mem_master_if.master: req_*/rsp_* toward the core, mem_* toward memory
//
// All mem_* outputs and rsp_* are flops; nothing on the memory side is
// combinationally reachable from req_*. Address and write data are frozen from
// the acceptance edge until the next acceptance, so they bracket the strobe by a
// full cycle on each side.
module mem_master
    import stack_arch_pkg::*;
#(
    parameter int AWIDTH      = AWIDTH_DEF,
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_master_if.master  bus
);

    if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
        $error("mem_master: WAIT_CYCLES must be >= 1");
    end

    localparam int              CW       = wait_cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mem_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Request captured at acceptance; these feed mem_addr/mem_wdata directly.
    logic              we_q, we_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;

    logic              mem_wr_q, mem_wr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              req_ready;
    logic              accept;
    logic              strobe_last;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // rst is folded in combinationally so the core never sees ready during
    // a reset cycle, even though the state register already reads IDLE.
    assign req_ready = (state_q == MS_IDLE) && !rst;
    assign accept    = bus.req_valid && req_ready;

    // Final STROBE cycle: the memory has had WAIT_CYCLES cycles of rd/wr.
    assign strobe_last = (state_q == MS_STROBE) && (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Next state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            MS_IDLE: begin
                if (accept) begin
                    state_d = MS_SETUP;
                    cnt_d   = '0;
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                end
            end

            MS_SETUP: begin
                state_d = MS_STROBE;
            end

            MS_STROBE: begin
                cnt_d = cnt_q + CW'(1);
                if (strobe_last) begin
                    state_d = MS_HOLD;
                    // mem_rdata is only trusted here, while rd has been high
                    // for the full wait; outside STROBE it may be Z/X.
                    if (!we_q) begin
                        rsp_rdata_d = bus.mem_rdata;
                    end
                end
            end

            MS_HOLD: begin
                state_d = MS_IDLE;
            end

            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the *next* state so that the registered
    // strobes line up exactly with the STROBE cycles (and rsp_valid with HOLD)
    // without any combinational decode on the outputs. we_q is already valid
    // whenever the next state is STROBE (we only get there via SETUP).
    always_comb begin
        mem_wr_d    = (state_d == MS_STROBE) &&  we_q;
        mem_rd_d    = (state_d == MS_STROBE) && !we_q;
        rsp_valid_d = (state_d == MS_HOLD);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MS_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_wr_q    <= mem_wr_d;
            mem_rd_q    <= mem_rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_rd    = mem_rd_q;

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: two instances (WAIT_CYCLES = 1 and 4), each attached to
// a behavioural word memory. One set of request drivers is steered to the
// selected instance; the expected per-cycle waveform of every transaction is
// derived from the documented latency and a reference copy of memory contents.
module tb_mem_master;
    import stack_arch_pkg::*;

    localparam int          AW   = 15;
    localparam int          DW   = 32;
    localparam int          MEMW = 1 << AW;
    // Stand-in for the memory's undriven data_out when rd is low.
    localparam logic [DW-1:0] JUNK = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_master_if #(.AWIDTH(AW), .DWIDTH(DW)) b1 ();
    mem_master_if #(.AWIDTH(AW), .DWIDTH(DW)) b4 ();

    mem_master #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.master)
    );

    mem_master #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.master)
    );

    // ---------------- request drivers, steered by sel ----------------
    int            sel;
    logic          req_valid;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    assign b1.req_valid = req_valid && (sel == 0);
    assign b4.req_valid = req_valid && (sel == 1);
    assign b1.req_we    = req_we;
    assign b4.req_we    = req_we;
    assign b1.req_addr  = req_addr;
    assign b4.req_addr  = req_addr;
    assign b1.req_wdata = req_wdata;
    assign b4.req_wdata = req_wdata;

    // ---------------- observed outputs of the selected instance ----------------
    logic          o_ready, o_rsp_valid, o_wr, o_rd;
    logic [DW-1:0] o_rdata, o_wdata;
    logic [AW-1:0] o_addr;

    always_comb begin
        if (sel == 1) begin
            o_ready = b4.req_ready; o_rsp_valid = b4.rsp_valid; o_rdata = b4.rsp_rdata;
            o_wr    = b4.mem_wr;    o_rd        = b4.mem_rd;    o_addr  = b4.mem_addr;
            o_wdata = b4.mem_wdata;
        end else begin
            o_ready = b1.req_ready; o_rsp_valid = b1.rsp_valid; o_rdata = b1.rsp_rdata;
            o_wr    = b1.mem_wr;    o_rd        = b1.mem_rd;    o_addr  = b1.mem_addr;
            o_wdata = b1.mem_wdata;
        end
    end

    // ---------------- memory models ----------------
    function automatic logic [DW-1:0] init_val(input int s, input int a);
        logic [DW-1:0] v;
        v = 32'h5A00_0000 ^ (DW'(s) << 20) ^ (DW'(a) * 32'h0000_9E37);
        return v;
    endfunction

    logic [DW-1:0] mem1 [MEMW];
    logic [DW-1:0] mem4 [MEMW];

    assign b1.mem_rdata = b1.mem_rd ? mem1[b1.mem_addr] : JUNK;
    assign b4.mem_rdata = b4.mem_rd ? mem4[b4.mem_addr] : JUNK;

    // Level-sensitive write: the word follows data_in for as long as wr is high.
    initial begin
        for (int i = 0; i < MEMW; i++) begin
            mem1[i] = init_val(0, i);
            mem4[i] = init_val(1, i);
        end
        mem4[15'h7FFF] = 32'h1234_5678;
        forever begin
            @(posedge clk);
            if (b1.mem_wr) mem1[b1.mem_addr] = b1.mem_wdata;
            if (b4.mem_wr) mem4[b4.mem_addr] = b4.mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ref_rdata [2];

    function automatic logic [DW-1:0] ref_read(input int s, input int a);
        int key;
        key = s * 65536 + a;
        if (ref_mem.exists(key)) return ref_mem[key];
        return init_val(s, a);
    endfunction

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request on instance s. Expected waveform relative to acceptance
    // edge E0: cycle 1 setup, cycles 2..w+1 strobe, w+2 response, w+3 ready.
    // hold=1 leaves req_valid high afterwards (back-to-back requester).
    task automatic xact(input int s, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit hold, output int acc);
        int            w;
        int            guard;
        logic [DW-1:0] old_rd, new_rd;
        bit            exp_wr, exp_rd;
        w         = (s == 1) ? 4 : 1;
        sel       = s;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        #1;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("accept_timeout", 64'(guard < 64), 64'(1));
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) req_valid = 1'b0;

        old_rd = ref_rdata[s];
        new_rd = we ? old_rd : ref_read(s, int'(a));
        if (we) ref_mem[s * 65536 + int'(a)] = d;

        for (int k = 1; k <= w + 3; k++) begin
            @(negedge clk);
            exp_wr =  we && (k >= 2) && (k <= w + 1);
            exp_rd = !we && (k >= 2) && (k <= w + 1);
            check("mem_wr",       64'(o_wr),          64'(exp_wr));
            check("mem_rd",       64'(o_rd),          64'(exp_rd));
            check("wr_rd_excl",   64'(o_wr & o_rd),   64'(0));
            check("rsp_valid",    64'(o_rsp_valid),   64'(k == w + 2));
            check("req_ready",    64'(o_ready),       64'(k == w + 3));
            if (k <= w + 2) begin
                check("mem_addr_held",  64'(o_addr),  64'(a));
                check("mem_wdata_held", 64'(o_wdata), 64'(d));
            end
            check("rsp_rdata", 64'(o_rdata), 64'((k >= w + 2) ? new_rd : old_rd));
        end
        ref_rdata[s] = new_rd;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            acc1, acc2;
        int            s;
        bit            we, hold;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        ref_mem[65536 + 32'h7FFF] = 32'h1234_5678;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        sel = 0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset values on both instances.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready_1",  64'(b1.req_ready), 64'(0));
        check("rst_ready_4",  64'(b4.req_ready), 64'(0));
        check("rst_rspv_1",   64'(b1.rsp_valid), 64'(0));
        check("rst_rspv_4",   64'(b4.rsp_valid), 64'(0));
        check("rst_wr_rd_1",  64'({b1.mem_wr, b1.mem_rd}), 64'(0));
        check("rst_wr_rd_4",  64'({b4.mem_wr, b4.mem_rd}), 64'(0));
        check("rst_addr_1",   64'(b1.mem_addr),  64'(0));
        check("rst_addr_4",   64'(b4.mem_addr),  64'(0));
        check("rst_wdata_1",  64'(b1.mem_wdata), 64'(0));
        check("rst_wdata_4",  64'(b4.mem_wdata), 64'(0));
        check("rst_rdata_1",  64'(b1.rsp_rdata), 64'(0));
        check("rst_rdata_4",  64'(b4.rsp_rdata), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_1", 64'(b1.req_ready), 64'(1));
        check("post_rst_ready_4", 64'(b4.req_ready), 64'(1));

        // Write then read back, WAIT_CYCLES=1.
        xact(0, 1'b1, 15'h0010, 32'hDEAD_BEEF, 1'b0, acc1);
        xact(0, 1'b0, 15'h0010, 32'h0000_0000, 1'b0, acc1);
        check("readback_0010", 64'(ref_rdata[0]), 64'(32'hDEAD_BEEF));

        // Preloaded top address, WAIT_CYCLES=4.
        xact(1, 1'b0, 15'h7FFF, 32'h0000_0000, 1'b0, acc1);
        check("read_7fff", 64'(b4.rsp_rdata), 64'(32'h1234_5678));

        // Back-to-back with req_valid held high.
        xact(0, 1'b1, 15'h0003, 32'hA5A5_A5A5, 1'b1, acc1);
        xact(0, 1'b0, 15'h0003, 32'h0000_0000, 1'b0, acc2);
        check("b2b_gap",  64'(acc2 - acc1), 64'(4));
        check("b2b_read", 64'(b1.rsp_rdata), 64'(32'hA5A5_A5A5));

        // Write leaves rsp_rdata alone; the following read updates it.
        xact(0, 1'b1, 15'h0005, 32'h0000_0001, 1'b0, acc1);
        xact(0, 1'b0, 15'h0005, 32'h0000_0000, 1'b0, acc1);
        check("read_0005", 64'(b1.rsp_rdata), 64'(32'h0000_0001));

        // Reset in the middle of a WAIT_CYCLES=4 read strobe.
        sel = 1; req_we = 1'b0; req_addr = 15'h0123; req_wdata = '0; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_rd_before", 64'(b4.mem_rd), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("abort_rd_dropped",  64'(b4.mem_rd),    64'(0));
        check("abort_no_rspv",     64'(b4.rsp_valid), 64'(0));
        check("abort_ready_inrst", 64'(b4.req_ready), 64'(0));
        check("abort_addr_clr",    64'(b4.mem_addr),  64'(0));
        rst = 1'b0;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_quiet_rspv",  64'(b4.rsp_valid), 64'(0));
            check("abort_quiet_rd",    64'(b4.mem_rd),    64'(0));
            check("abort_quiet_ready", 64'(b4.req_ready), 64'(1));
        end
        xact(1, 1'b0, 15'h0000, 32'h0000_0000, 1'b0, acc1);
        check("fresh_read_0000", 64'(b4.rsp_rdata), 64'(init_val(1, 0)));

        // Random traffic on both instances.
        for (int i = 0; i < 60; i++) begin
            s  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       a = 15'h0000;
                1:       a = 15'h0003;
                2:       a = 15'h0005;
                3:       a = 15'h7FFF;
                default: a = AW'($urandom_range(0, MEMW - 1));
            endcase
            d    = $urandom;
            hold = (i < 59) && ($urandom_range(0, 1) == 1);
            xact(s, we, a, d, hold, acc1);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
